// File: rtl/instr_fifo.sv
// instr_fifo: show-ahead FIFO of display instruction words feeding the SPI
// instruction engine. A producer pushes with a valid/ready handshake and the
// engine pops one word per byte boundary using the serial-clock strobe.
//
// Handshake semantics:
//   write side - a word transfers on a rising clk edge when wrValid and
//   wrReady are both high. wrReady depends only on registered state (plus
//   reset/flush), never on rdStrobe, so a full FIFO refuses a push even in
//   a cycle where a pop also happens.
//   read side  - rdData/rdValid show the head word combinationally. A
//   rdStrobe pulse pops the head only while rdValid is high; a strobe on an
//   empty FIFO does nothing except set the sticky underrun flag.
module instr_fifo #(
  parameter int dataBits        = 10,
  parameter int depthBits       = 4,
  parameter int almostFullLevel = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [dataBits-1:0] wrData,
  input  logic                wrValid,
  output logic                wrReady,
  output logic [dataBits-1:0] rdData,
  output logic                rdValid,
  input  logic                rdStrobe,
  output logic [depthBits:0]  count,
  output logic                almostFull,
  output logic                overflow,
  output logic                underrun
);

  localparam int depth = 2 ** depthBits;

  logic [dataBits-1:0] mem [depth];
  logic [depthBits:0]  wr_ptr;
  logic [depthBits:0]  rd_ptr;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;

  // Occupancy, flags and handshake decode from the registered pointers.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[depthBits] != rd_ptr[depthBits]) &&
                 (wr_ptr[depthBits-1:0] == rd_ptr[depthBits-1:0]);
    count      = wr_ptr - rd_ptr;
    almostFull = (count >= (depthBits+1)'(almostFullLevel));
    wrReady    = !full && !reset && !flush;
    rdValid    = !empty;
    rdData     = mem[rd_ptr[depthBits-1:0]];
    push       = wrValid && wrReady;
    pop        = rdStrobe && rdValid && !reset && !flush;
  end

  // Pointers and sticky error flags; reset and flush clear identically and
  // discard any push or pop offered in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (depthBits+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (depthBits+1)'(1);
      if (wrValid && !wrReady) overflow <= 1'b1;
      if (rdStrobe && !rdValid) underrun <= 1'b1;
    end
  end

  // Storage write; contents are never cleared, only made unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[depthBits-1:0]] <= wrData;
  end

endmodule

// File: tb/tb_instr_fifo.sv
// tb_instr_fifo: directed self-checking bench for instr_fifo.
module tb_instr_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [9:0] wrData;
  logic       wrValid;
  logic       wrReady;
  logic [9:0] rdData;
  logic       rdValid;
  logic       rdStrobe;
  logic [4:0] count;
  logic       almostFull;
  logic       overflow;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  instr_fifo #(.dataBits(10), .depthBits(4), .almostFullLevel(12)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .rdStrobe(rdStrobe),
    .count(count), .almostFull(almostFull),
    .overflow(overflow), .underrun(underrun)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // checking task
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrValid  = 1'b0;
    rdStrobe = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("wrReady_in_reset", wrReady, 0);
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic push_word(input logic [9:0] d);
    wrData  = d;
    wrValid = 1'b1;
    step();
    wrValid = 1'b0;
  endtask

  task automatic pop_word();
    rdStrobe = 1'b1;
    step();
    rdStrobe = 1'b0;
  endtask

  // scoreboard: pop checks the head against the expected queue
  task automatic pop_check(input string tag);
    logic [9:0] e;
    e = exp_q.pop_front();
    check_eq(tag, rdData, e);
    pop_word();
  endtask

  task automatic pushpop_check(input string tag, input logic [9:0] d);
    logic [9:0] e;
    e = exp_q.pop_front();
    check_eq(tag, rdData, e);
    exp_q.push_back(d);
    wrData   = d;
    wrValid  = 1'b1;
    rdStrobe = 1'b1;
    step();
    wrValid  = 1'b0;
    rdStrobe = 1'b0;
  endtask

  initial begin
    wrData = '0;
    idle();
    do_reset();

    // 1: reset state, three pushes, three pops
    check_eq("rst_count", count, 0);
    check_eq("rst_rdValid", rdValid, 0);
    check_eq("rst_almostFull", almostFull, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_wrReady_after", wrReady, 1);
    push_word(10'h3A5);
    check_eq("t1_latency_valid", rdValid, 1);
    check_eq("t1_latency_data", rdData, 10'h3A5);
    push_word(10'h0FF);
    push_word(10'h200);
    check_eq("t1_count3", count, 3);
    check_eq("t1_head", rdData, 10'h3A5);
    pop_word();
    check_eq("t1_pop1", rdData, 10'h0FF);
    pop_word();
    check_eq("t1_pop2", rdData, 10'h200);
    pop_word();
    check_eq("t1_empty", rdValid, 0);
    check_eq("t1_count0", count, 0);
    check_eq("t1_no_underrun", underrun, 0);

    // 2: fill to 16, almostFull threshold, overflow attempt
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push_word(10'(i));
      check_eq($sformatf("t2_count_%0d", i + 1), count, i + 1);
      check_eq($sformatf("t2_afull_%0d", i + 1), almostFull, (i + 1 >= 12) ? 1 : 0);
    end
    check_eq("t2_wrReady_full", wrReady, 0);
    check_eq("t2_overflow_pre", overflow, 0);
    push_word(10'h3FF);
    check_eq("t2_overflow", overflow, 1);
    check_eq("t2_count_held", count, 16);
    check_eq("t2_head_unchanged", rdData, 10'h000);

    // 3: full, simultaneous pop and refused push
    wrData   = 10'h155;
    wrValid  = 1'b1;
    rdStrobe = 1'b1;
    #1;
    check_eq("t3_wrReady_before", wrReady, 0);
    step();
    wrValid  = 1'b0;
    rdStrobe = 1'b0;
    check_eq("t3_count15", count, 15);
    check_eq("t3_overflow", overflow, 1);
    check_eq("t3_head", rdData, 10'h001);
    check_eq("t3_wrReady_after", wrReady, 1);
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("t3_drain_%0d", i), rdData, 10'(i));
      pop_word();
    end
    check_eq("t3_drained", rdValid, 0);

    // 4: simultaneous push/pop at count=5, then 40 wrap-around pairs
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_word(10'(16 + i));
      exp_q.push_back(10'(16 + i));
    end
    check_eq("t4_count5", count, 5);
    pushpop_check("t4_pp_head", 10'h111);
    check_eq("t4_count_same", count, 5);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t4_pop_%0d", i));
    check_eq("t4_fifth_is_111", rdData, 10'h111);
    pop_check("t4_pop_111");
    check_eq("t4_empty", rdValid, 0);
    for (int i = 0; i < 3; i++) begin
      push_word(10'(10'h200 + i));
      exp_q.push_back(10'(10'h200 + i));
    end
    for (int i = 0; i < 40; i++) begin
      pushpop_check($sformatf("t4_wrap_%0d", i), 10'(10'h040 + i * 7));
      if (count != 3) check_eq($sformatf("t4_wrap_count_%0d", i), count, 3);
    end
    check_eq("t4_wrap_count", count, 3);
    for (int i = 0; i < 3; i++) pop_check($sformatf("t4_tail_%0d", i));
    check_eq("t4_final_empty", rdValid, 0);

    // 5: empty, strobe with push
    do_reset();
    wrData   = 10'h2AA;
    wrValid  = 1'b1;
    rdStrobe = 1'b1;
    step();
    wrValid  = 1'b0;
    rdStrobe = 1'b0;
    check_eq("t5_underrun", underrun, 1);
    check_eq("t5_count1", count, 1);
    check_eq("t5_rdValid", rdValid, 1);
    check_eq("t5_data", rdData, 10'h2AA);

    // 6: count=7 with overflow set, then flush (mode 0) or reset (mode 1)
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      for (int i = 0; i < 16; i++) push_word(10'(i));
      push_word(10'h3FF);
      for (int i = 0; i < 9; i++) pop_word();
      check_eq($sformatf("t6_m%0d_count7", mode), count, 7);
      check_eq($sformatf("t6_m%0d_ovf_set", mode), overflow, 1);
      wrData  = 10'h3C3;
      wrValid = 1'b1;
      if (mode == 0) flush = 1'b1;
      else reset = 1'b1;
      #1;
      check_eq($sformatf("t6_m%0d_wrReady_low", mode), wrReady, 0);
      step();
      idle();
      #1;
      check_eq($sformatf("t6_m%0d_count0", mode), count, 0);
      check_eq($sformatf("t6_m%0d_rdValid0", mode), rdValid, 0);
      check_eq($sformatf("t6_m%0d_ovf_clr", mode), overflow, 0);
      check_eq($sformatf("t6_m%0d_afull_clr", mode), almostFull, 0);
      check_eq($sformatf("t6_m%0d_wrReady", mode), wrReady, 1);
      push_word(10'h1E1);
      check_eq($sformatf("t6_m%0d_first_push", mode), rdData, 10'h1E1);
      check_eq($sformatf("t6_m%0d_count1", mode), count, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
